pte_ad_update_unit: RTL

Page-table-walker companion that writes the Accessed/Dirty bits back into a leaf PTE after the permission/privilege check has passed. It takes the walked PTE and its physical address, computes the required A/D update, and skips memory traffic entirely if none is needed. Otherwise it re-reads the PTE to confirm it is unchanged, writes the updated value, and reports the outcome to the walker FSM. It sits between the PTW control FSM and the PTW memory port.

---
 rtl/mmu_pkg.sv | 48 ++++
 rtl/pte_ad_update_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mmu_pkg.sv
// Shared MMU definitions: PTE bit positions, A/D-update response codes,
// the A/D update unit state encoding and the A/D merge helper.
package mmu_pkg;

  // Leaf PTE flag bit positions (RISC-V Sv39/Sv48 layout).
  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;
  localparam int unsigned PTE_U = 4;
  localparam int unsigned PTE_G = 5;
  localparam int unsigned PTE_A = 6;
  localparam int unsigned PTE_D = 7;

  // Widest PTE the merge helper handles.
  localparam int unsigned PTE_MERGE_W = 64;

  // Outcome reported back to the walker FSM.
  typedef enum logic [1:0] {
    RESP_UPDATED   = 2'b00,
    RESP_NO_UPDATE = 2'b01,
    RESP_RETRY     = 2'b10,
    RESP_BUS_ERR   = 2'b11
  } resp_status_e;

  // A/D update unit sequencing.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } ad_state_e;

  // Sets A always and D for stores; every other bit passes through.
  function automatic logic [PTE_MERGE_W-1:0] pte_ad_merge(
    input logic [PTE_MERGE_W-1:0] pte,
    input logic                   store
  );
    logic [PTE_MERGE_W-1:0] merged;
    merged        = pte;
    merged[PTE_A] = 1'b1;
    if (store) merged[PTE_D] = 1'b1;
    return merged;
  endfunction

endpackage

// File: rtl/pte_ad_update_unit.sv
// Accessed/Dirty write-back unit for the page-table walker. Re-reads the leaf
// PTE to make sure nobody changed it since the walk, then writes the merged
// A/D value. Requests that need no change complete without memory traffic.
// XLEN must lie in 8..64 so the A/D bits exist and fit the merge helper.
module pte_ad_update_unit
  import mmu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PADDR_W = 56
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PADDR_W-1:0] req_pte_addr,
  input  logic [XLEN-1:0]    req_pte,
  input  logic               req_store,
  output logic               resp_valid,
  output logic [1:0]         resp_status,
  output logic [XLEN-1:0]    resp_pte,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_rw,
  output logic [PADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]    mem_req_wdata,
  input  logic               mem_resp_valid,
  input  logic [XLEN-1:0]    mem_resp_rdata,
  input  logic               mem_resp_err
);

  ad_state_e        state;
  logic [XLEN-1:0]  pte_q;      // PTE as walked
  logic [XLEN-1:0]  new_pte_q;  // PTE with A/D merged in
  logic [XLEN-1:0]  new_pte;

  // Merge evaluated on the incoming request so the no-update case is decided at acceptance.
  assign new_pte = XLEN'(pte_ad_merge(PTE_MERGE_W'(req_pte), req_store));

  // Sequencer with all outputs registered; memory request fields are loaded once
  // on entry to a request state and held until the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every register, including the latched PTE copies, is cleared so a
      // reset mid-transaction cannot leak stale data into the next request.
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_status   <= RESP_UPDATED;
      resp_pte      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      pte_q         <= '0;
      new_pte_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so each branch reads the
      // pre-edge register values regardless of statement order.
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            pte_q     <= req_pte;
            new_pte_q <= new_pte;
            req_ready <= 1'b0;
            if (new_pte == req_pte) begin
              state       <= ST_DONE;
              resp_valid  <= 1'b1;
              resp_status <= RESP_NO_UPDATE;
              resp_pte    <= req_pte;
            end else begin
              state         <= ST_RD_REQ;
              mem_req_valid <= 1'b1;
              mem_req_rw    <= 1'b0;
              mem_req_addr  <= req_pte_addr;
            end
          end
        end

        // Responses arriving here are not ours; only the ready is observed.
        ST_RD_REQ: begin
          if (mem_req_ready) begin
            state         <= ST_RD_WAIT;
            mem_req_valid <= 1'b0;
          end
        end

        ST_RD_WAIT: begin
          if (mem_resp_valid) begin
            if (mem_resp_err) begin
              state       <= ST_DONE;
              resp_valid  <= 1'b1;
              resp_status <= RESP_BUS_ERR;
              resp_pte    <= pte_q;
            end else if (mem_resp_rdata != pte_q) begin
              // PTE changed under us: hand the fresh value back for a re-walk.
              state       <= ST_DONE;
              resp_valid  <= 1'b1;
              resp_status <= RESP_RETRY;
              resp_pte    <= mem_resp_rdata;
            end else begin
              state         <= ST_WR_REQ;
              mem_req_valid <= 1'b1;
              mem_req_rw    <= 1'b1;
              mem_req_wdata <= new_pte_q;
            end
          end
        end

        ST_WR_REQ: begin
          if (mem_req_ready) begin
            state         <= ST_WR_WAIT;
            mem_req_valid <= 1'b0;
          end
        end

        ST_WR_WAIT: begin
          if (mem_resp_valid) begin
            state      <= ST_DONE;
            resp_valid <= 1'b1;
            if (mem_resp_err) begin
              resp_status <= RESP_BUS_ERR;
              resp_pte    <= pte_q;
            end else begin
              resp_status <= RESP_UPDATED;
              resp_pte    <= new_pte_q;
            end
          end
        end

        ST_DONE: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end

        default: begin
          state         <= ST_IDLE;
          resp_valid    <= 1'b0;
          req_ready     <= 1'b1;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
